// File: rtl/d_latch_reader_pkg.sv
// Shared defaults for the latch-reader block and its FIFO.
package d_latch_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 2;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/d_latch_reader_if.sv
// Bundle between a latch-style producer / downstream consumer and the reader.
interface d_latch_reader_if
  import d_latch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = count_width(DEPTH)
);

  logic [WIDTH-1:0] d;
  logic             en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] held_q;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             clr_ovf;

  // Environment side: drives producer data, downstream ready and clears.
  modport master (
    output d, en, out_ready, clr_ovf,
    input  out_data, out_valid, held_q, count, overflow
  );

  // Reader side.
  modport slave (
    input  d, en, out_ready, clr_ovf,
    output out_data, out_valid, held_q, count, overflow
  );

endinterface

// File: rtl/d_latch_reader_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module d_latch_reader_fifo
  import d_latch_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             push_acc
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_ok   = pop & ~empty;
    push_acc = push & (~full | pop_ok);
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)   rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + CW'(push_acc) - CW'(pop_ok);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  // NOTE: the memory is deliberately not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= wdata;
  end

  // Head of queue, forced to zero when nothing is stored.
  always_comb begin
    rdata = '0;
    if (!empty) rdata = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/d_latch_reader.sv
// Turns each close of a latch-style producer (en high then low) into one FIFO
// entry, and exports the currently held value plus a sticky overflow flag.
module d_latch_reader
  import d_latch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = count_width(DEPTH)
) (
  input logic             clk,
  input logic             rst,
  d_latch_reader_if.slave bus
);

  logic             en_q, en_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] held_q, held_d;
  logic             ovf_q, ovf_d;
  logic             fall;
  logic             pop;
  logic             push_acc;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH-1:0] fifo_rdata;

  // Edge detect, latch-mirroring sample, held value and sticky overflow.
  always_comb begin
    en_d   = bus.en;
    d_d    = d_q;
    held_d = held_q;
    ovf_d  = ovf_q;
    fall   = en_q & ~bus.en;
    if (bus.en) d_d = bus.d;
    if (fall)   held_d = d_q;
    // A rejected push takes priority over a clear in the same cycle.
    if (fall && !push_acc) ovf_d = 1'b1;
    else if (bus.clr_ovf)  ovf_d = 1'b0;
  end

  // State registers for the producer-facing side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      d_q    <= '0;
      held_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      d_q    <= d_d;
      held_q <= held_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pop = ~fifo_empty & bus.out_ready;

  d_latch_reader_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fall),
    .wdata    (d_q),
    .pop      (pop),
    .rdata    (fifo_rdata),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .push_acc (push_acc)
  );

  assign bus.out_data  = fifo_rdata;
  assign bus.out_valid = ~fifo_empty;
  assign bus.held_q    = held_q;
  assign bus.count     = fifo_count;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_d_latch_reader.sv
// Bench for d_latch_reader: directed scenarios plus a randomized run, all
// checked against a queue-based behavioural model of the reader.
module tb_d_latch_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  d_latch_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();

  d_latch_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of captured bytes plus a few state values.
  logic [WIDTH-1:0] m_q [$];
  logic [WIDTH-1:0] m_held;
  logic [WIDTH-1:0] m_last_d;
  logic             m_en_prev;
  logic             m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_held    = '0;
    m_last_d  = '0;
    m_en_prev = 1'b0;
    m_ovf     = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit was_full, popped, closing;
    was_full = (m_q.size() == DEPTH);
    popped   = (m_q.size() > 0) && bus.out_ready;
    closing  = m_en_prev && !bus.en;
    if (popped) void'(m_q.pop_front());
    if (closing) begin
      m_held = m_last_d;
      if (!was_full || popped) m_q.push_back(m_last_d);
    end
    if (closing && was_full && !popped) m_ovf = 1'b1;
    else if (bus.clr_ovf)               m_ovf = 1'b0;
    if (bus.en) m_last_d = bus.d;
    m_en_prev = bus.en;
  endtask

  function automatic logic [WIDTH-1:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : '0;
  endfunction

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic cycle();
    if (rst) model_reset();
    else     model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic close_event(input logic [WIDTH-1:0] v);
    bus.en = 1'b1; bus.d = v; cycle();
    bus.en = 1'b0;            cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (10) cycle();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.held_q !== '0) begin n_fail++; $display("FAIL reset_held: got %h want 00", bus.held_q); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.out_data); end
  endtask

  task automatic test_single_close();
    bus.out_ready = 1'b0;
    bus.en = 1'b1; bus.d = 8'h5A;
    repeat (3) cycle();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_early_valid: got %b want 0", bus.out_valid); end
    bus.en = 1'b0; bus.d = 8'hFF;
    cycle();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_data !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %h want 5a", bus.out_data); end
    n_checks++; if (bus.held_q !== 8'h5A) begin n_fail++; $display("FAIL single_held: got %h want 5a", bus.held_q); end
    n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL single_count: got %0d want 1", bus.count); end
    cycle();
    n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL single_one_event: got %0d want 1", bus.count); end
    n_checks++; if (bus.out_data !== 8'h5A) begin n_fail++; $display("FAIL single_stable: got %h want 5a", bus.out_data); end
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    close_event(8'h11);
    close_event(8'h22);
    close_event(8'h33);
    n_checks++; if (bus.count !== CW'(2)) begin n_fail++; $display("FAIL ovf_count: got %0d want 2", bus.count); end
    n_checks++; if (bus.out_data !== 8'h11) begin n_fail++; $display("FAIL ovf_head: got %h want 11", bus.out_data); end
    n_checks++; if (bus.held_q !== 8'h33) begin n_fail++; $display("FAIL ovf_held: got %h want 33", bus.held_q); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    bus.out_ready = 1'b1;
    cycle();
    n_checks++; if (bus.out_data !== 8'h22) begin n_fail++; $display("FAIL ovf_drain1: got %h want 22", bus.out_data); end
    n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL ovf_drain1_count: got %0d want 1", bus.count); end
    cycle();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain2: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    bus.out_ready = 1'b0; bus.clr_ovf = 1'b1;
    cycle();
    bus.clr_ovf = 1'b0;
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
  endtask

  task automatic test_full_pop_push();
    bus.out_ready = 1'b0;
    close_event(8'h01);
    close_event(8'h02);
    bus.en = 1'b1; bus.d = 8'h03; cycle();
    bus.en = 1'b0; bus.out_ready = 1'b1; cycle();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.count !== CW'(2)) begin n_fail++; $display("FAIL fpp_count: got %0d want 2", bus.count); end
    n_checks++; if (bus.out_data !== 8'h02) begin n_fail++; $display("FAIL fpp_head: got %h want 02", bus.out_data); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b want 0", bus.overflow); end
    n_checks++; if (bus.held_q !== 8'h03) begin n_fail++; $display("FAIL fpp_held: got %h want 03", bus.held_q); end
    // Rejected push with a simultaneous clear: the set must win.
    bus.en = 1'b1; bus.d = 8'h04; cycle();
    bus.en = 1'b0; bus.clr_ovf = 1'b1; cycle();
    bus.clr_ovf = 1'b0;
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL set_wins: got %b want 1", bus.overflow); end
    n_checks++; if (bus.held_q !== 8'h04) begin n_fail++; $display("FAIL set_wins_held: got %h want 04", bus.held_q); end
    bus.clr_ovf = 1'b1; cycle();
    bus.clr_ovf = 1'b0;
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL clear_after: got %b want 0", bus.overflow); end
    bus.out_ready = 1'b1;
    cycle();
    n_checks++; if (bus.out_data !== 8'h03) begin n_fail++; $display("FAIL fpp_second: got %h want 03", bus.out_data); end
    cycle();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_hold();
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.d = (i % 2 == 0) ? 8'h00 : 8'hAA;
      cycle();
    end
    n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL hold_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.held_q !== 8'h04) begin n_fail++; $display("FAIL hold_held: got %h want 04", bus.held_q); end
    bus.en = 1'b1; bus.d = 8'hAA; cycle();
    bus.en = 1'b0; bus.d = 8'h00; cycle();
    cycle();
    n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL pulse_count: got %0d want 1", bus.count); end
    n_checks++; if (bus.out_data !== 8'hAA) begin n_fail++; $display("FAIL pulse_data: got %h want aa", bus.out_data); end
    bus.out_ready = 1'b1; cycle(); bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    close_event(8'h11);
    close_event(8'h22);
    close_event(8'h33);
    bus.out_ready = 1'b1; cycle(); bus.out_ready = 1'b0;
    n_checks++; if (bus.count !== CW'(1) || bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL areset_setup: got count=%0d ovf=%b want count=1 ovf=1", bus.count, bus.overflow);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL areset_ovf: got %b want 0", bus.overflow); end
    n_checks++; if (bus.held_q !== '0) begin n_fail++; $display("FAIL areset_held: got %h want 00", bus.held_q); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL areset_data: got %h want 00", bus.out_data); end
    model_reset();
    bus.en = 1'b1; bus.d = 8'h77;
    rst = 1'b0;
    cycle();
    bus.en = 1'b0; bus.d = 8'h00;
    cycle();
    n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL post_reset_count: got %0d want 1", bus.count); end
    n_checks++; if (bus.out_data !== 8'h77) begin n_fail++; $display("FAIL post_reset_data: got %h want 77", bus.out_data); end
    n_checks++; if (bus.held_q !== 8'h77) begin n_fail++; $display("FAIL post_reset_held: got %h want 77", bus.held_q); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.en        = $urandom_range(0, 1) == 1;
      bus.d         = WIDTH'($urandom);
      bus.out_ready = $urandom_range(0, 9) < 4;
      bus.clr_ovf   = $urandom_range(0, 9) == 0;
      cycle();
      n_checks++; if (bus.out_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.out_valid, m_q.size() > 0); end
      n_checks++; if (bus.count !== CW'(m_q.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, bus.count, m_q.size()); end
      n_checks++; if (bus.out_data !== m_head()) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, bus.out_data, m_head()); end
      n_checks++; if (bus.held_q !== m_held) begin n_fail++; $display("FAIL rnd_held[%0d]: got %h want %h", i, bus.held_q, m_held); end
      n_checks++; if (bus.overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, bus.overflow, m_ovf); end
    end
    bus.en = 1'b0; bus.out_ready = 1'b0; bus.clr_ovf = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.d         = '0;
    bus.en        = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    model_reset();
    test_reset();
    test_single_close();
    test_overflow();
    test_full_pop_push();
    test_hold();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_latch_reader.md
Name: d_latch_reader

Overview:
- Consumer-side counterpart of the team's level-sensitive D latch.
- Watches a latch-style producer (data d plus level enable en) and converts each "close" event into one discrete transfer. A close event is en going high then low, which is the moment the latch freezes its value.
- Captured values are queued in a small FIFO and presented downstream on a valid/ready interface.
- Also exports the currently held value and a sticky overflow flag, for synchronous logic that reads latch outputs.

Parameters:
- WIDTH, 8: data width of d, held_q and out_data.
- DEPTH, 2: FIFO entries; power of 2, minimum 2.
- CW, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- d  in  WIDTH  producer data, latch D input.
- en  in  1  producer enable; high means transparent, low means hold.
- out_data  out  WIDTH  FIFO head value.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts out_data this cycle.
- held_q  out  WIDTH  value frozen at the most recent close event.
- count  out  CW  FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky; a close event was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release): en_q=0, d_q=0, held_q=0, FIFO empty, count=0, out_valid=0, out_data=0, overflow=0.
- Sampling registers:
  - en_q <= en every cycle.
  - d_q <= d on cycles where en=1; d_q holds while en=0, mirroring latch hold.
- Close event: fall = en_q & ~en. Captured value is d_q, the last d sampled with en high. The d present in the fall cycle is ignored.
- On fall: held_q <= d_q, regardless of FIFO state.
- Push and pop:
  - Push request = fall. Pop = out_valid & out_ready.
  - Push accepted if count<DEPTH, or if a pop occurs the same cycle (full + simultaneous pop + push is legal; count unchanged).
  - Push rejected (full, no pop): the value is dropped, overflow <= 1. held_q still updates.
- Count: count <= count + push_acc - pop. It never exceeds DEPTH and never goes below 0.
- Pop when empty is impossible, since out_valid=0.
- Pointers: width $clog2(DEPTH), wrap modulo DEPTH.
- Empty-FIFO push: out_valid rises the cycle after the fall edge. There is no same-cycle bypass.
- out_data is driven from FIFO memory at the read pointer. It is stable while out_valid=1 and out_ready=0.
- Latency: en sampled low at edge k (high at k-1) gives out_valid=1 and held_q updated after edge k, i.e. 1 cycle.
- overflow:
  - Set on a rejected push; cleared only by clr_ovf or rst.
  - If clr_ovf and a rejected push occur in the same cycle, set wins.
- en held high: no events; d_q tracks d.
- en held low: no events.
- en pulse of one cycle high: d_q captured, then fall on the next cycle produces exactly one event.
- Reset mid-operation clears everything. An en already high at reset release produces an event on its next fall, because en_q is sampled after reset.
- Behaviour for en changes shorter than a clock period is undefined. en and d are synchronous to clk.

Decomposition:
- Package d_latch_pkg: DEFAULT_WIDTH=8, DEFAULT_DEPTH=2.
- One sub-module: d_latch_reader_fifo (parameterised WIDTH/DEPTH synchronous FIFO; push/pop/count/full/empty).
- Top level holds edge detect, d_q, held_q and overflow.

Test Plan:
- Reset then idle: rst pulse, en=0 for 10 cycles -> out_valid=0, count=0, held_q=0, overflow=0.
- Single close: en=1 with d=0x5A for 3 cycles, then en=0 with d=0xFF, out_ready=0 -> one cycle later out_valid=1, out_data=0x5A, held_q=0x5A, count=1. The 0xFF is not captured.
- Back-pressure and overflow: out_ready=0, three close events with values 0x11, 0x22, 0x33 ->
  - count=2, out_data=0x11, held_q=0x33, overflow=1.
  - Then out_ready=1 drains 0x11, then 0x22, and out_valid drops.
- Full + simultaneous pop/push: FIFO full (0x01, 0x02), out_ready=1 in the same cycle as a fall capturing 0x03 -> 0x01 popped, 0x03 accepted, count stays 2, overflow stays 0.
- Hold behaviour: en=0 while d toggles 0x00/0xAA for 5 cycles -> no events, held_q unchanged. Then en=1 with d=0xAA for 1 cycle, then en=0 -> exactly one entry 0xAA.
- Async reset mid-operation: rst asserted between clock edges with count=1 and overflow=1 -> all outputs 0 immediately. After release with en=1 then en=0, one event is captured.
